// File: rtl/risc16_core.sv
// risc16_core: multicycle 16-bit RISC CPU with a 256x16 unified RAM and a host load port.
// Build option: define RISC16_SHIFT_EN to include the SHL/SHR barrel shifter (opcodes 6/7 are NOPs otherwise).
module risc16_core (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        E,
  input  logic [15:0] Ram_addr,
  input  logic [15:0] Ram_data,
  input  logic        WR_RAM_E,
  output logic [15:0] out_data,
  output logic        done
);
  // state | meaning
  // FETCH | IR <= RAM[PC], PC <= PC+1
  // EXEC  | execute IR, update regs/PC/RAM/out_data
  // HALT  | stopped until reset, done held high

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [15:0] mem  [256];
  logic [15:0] regs [8];
  logic [7:0]  pc;
  logic [15:0] ir;

  logic [3:0]  op;
  logic [2:0]  rd, rs, rt;
  logic [15:0] imm6_x, imm9_x;
  logic [15:0] rs_val, rt_val, rd_val;
  logic [7:0]  ea;
  logic        reg_we;
  logic [15:0] reg_wd;
  logic        unused_addr_hi;

  assign op     = ir[15:12];
  assign rd     = ir[11:9];
  assign rs     = ir[8:6];
  assign rt     = ir[5:3];
  assign imm6_x = {{10{ir[5]}}, ir[5:0]};
  assign imm9_x = {{7{ir[8]}}, ir[8:0]};
  assign rs_val = regs[rs];
  assign rt_val = regs[rt];
  assign rd_val = regs[rd];
  assign ea     = rs_val[7:0] + imm6_x[7:0];

  assign unused_addr_hi = ^Ram_addr[15:8];

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = (op == 4'hF) ? HALT : FETCH;
      default: state_nxt = HALT;
    endcase
  end

  // Register-file write-back; only acted on in EXEC
  always_comb begin
    reg_we = 1'b0;
    reg_wd = '0;
    case (op)
      4'h1: begin reg_we = 1'b1; reg_wd = rs_val + rt_val; end
      4'h2: begin reg_we = 1'b1; reg_wd = rs_val - rt_val; end
      4'h3: begin reg_we = 1'b1; reg_wd = rs_val & rt_val; end
      4'h4: begin reg_we = 1'b1; reg_wd = rs_val | rt_val; end
      4'h5: begin reg_we = 1'b1; reg_wd = rs_val ^ rt_val; end
`ifdef RISC16_SHIFT_EN
      4'h6: begin reg_we = 1'b1; reg_wd = rs_val << rt_val[3:0]; end
      4'h7: begin reg_we = 1'b1; reg_wd = rs_val >> rt_val[3:0]; end
`endif
      4'h8: begin reg_we = 1'b1; reg_wd = imm9_x; end
      4'h9: begin reg_we = 1'b1; reg_wd = mem[ea]; end
      4'hE: begin reg_we = 1'b1; reg_wd = rs_val + imm6_x; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= '0;
      ir       <= '0;
      out_data <= '0;
      done     <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (E) begin
      state <= state_nxt;
      case (state)
        FETCH: begin
          ir <= mem[pc];
          pc <= pc + 8'd1;
        end
        EXEC: begin
          if (reg_we) regs[rd] <= reg_wd;
          if (op == 4'hB && rd_val == rs_val) pc <= pc + imm6_x[7:0];
          if (op == 4'hC) pc <= ir[7:0];
          if (op == 4'hD) out_data <= rd_val;
          if (op == 4'hF) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // RAM has no reset; host writes only while stalled, ST only in EXEC
  always_ff @(posedge CLK) begin
    if (rst_n) begin
      if (!E && WR_RAM_E)
        mem[Ram_addr[7:0]] <= Ram_data;
      else if (E && state == EXEC && op == 4'hA)
        mem[ea] <= rd_val;
    end
  end

endmodule

// File: tb/tb_risc16_core.sv
// Self-checking bench for risc16_core: directed program table, hand-timed sequences,
// and random programs compared against an instruction-level ISA model.
module tb_risc16_core;
  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        E = 1'b0;
  logic [15:0] Ram_addr = '0;
  logic [15:0] Ram_data = '0;
  logic        WR_RAM_E = 1'b0;
  logic [15:0] out_data;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef RISC16_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  always #5 CLK = ~CLK;

  risc16_core dut (
    .CLK(CLK), .rst_n(rst_n), .E(E), .Ram_addr(Ram_addr), .Ram_data(Ram_data),
    .WR_RAM_E(WR_RAM_E), .out_data(out_data), .done(done)
  );

  // ISA-level reference model
  logic [15:0] m_mem [256];
  logic [15:0] m_r [8];
  logic [7:0]  m_pc;
  logic [15:0] m_out;
  logic        m_done;

  typedef logic [7:0][15:0] prog_t;
  typedef struct packed {
    prog_t       prog;
    logic [15:0] exp_out;
    logic [7:0]  exp_edge;
  } vec_t;
  vec_t vt [8];

  function automatic prog_t mk(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7);
    prog_t p;
    p[0] = w0; p[1] = w1; p[2] = w2; p[3] = w3;
    p[4] = w4; p[5] = w5; p[6] = w6; p[7] = w7;
    return p;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    E = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic tb_load(input logic [7:0] addr, input logic [15:0] data);
    Ram_addr = {8'h00, addr};
    Ram_data = data;
    WR_RAM_E = 1'b1;
    m_mem[addr] = data;
    tick();
    WR_RAM_E = 1'b0;
  endtask

  task automatic load_vec(input int idx);
    for (int j = 0; j < 8; j++) tb_load(8'(j), vt[idx].prog[j]);
  endtask

  task automatic run_until_done(input int limit, output int edge_n);
    E = 1'b1;
    edge_n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (done === 1'b1) begin
        edge_n = i;
        break;
      end
    end
    E = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_pc = '0;
    m_out = '0;
    m_done = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] ir, a, b, d, i6;
    logic [2:0]  rd, rs, rt;
    ir = m_mem[m_pc];
    m_pc = m_pc + 8'd1;
    rd = ir[11:9]; rs = ir[8:6]; rt = ir[5:3];
    i6 = {{10{ir[5]}}, ir[5:0]};
    a = m_r[rs]; b = m_r[rt]; d = m_r[rd];
    case (ir[15:12])
      4'h1: m_r[rd] = a + b;
      4'h2: m_r[rd] = a - b;
      4'h3: m_r[rd] = a & b;
      4'h4: m_r[rd] = a | b;
      4'h5: m_r[rd] = a ^ b;
      4'h6: if (SHIFT_EN) m_r[rd] = a << b[3:0];
      4'h7: if (SHIFT_EN) m_r[rd] = a >> b[3:0];
      4'h8: m_r[rd] = {{7{ir[8]}}, ir[8:0]};
      4'h9: m_r[rd] = m_mem[8'(a + i6)];
      4'hA: m_mem[8'(a + i6)] = d;
      4'hB: if (d == a) m_pc = m_pc + i6[7:0];
      4'hC: m_pc = ir[7:0];
      4'hD: m_out = d;
      4'hE: m_r[rd] = a + i6;
      4'hF: m_done = 1'b1;
      default: ;
    endcase
  endtask

  initial begin
    int e_n, c;
    logic [15:0] w;
    logic [3:0]  opr;

    vt[0] = '{mk(16'h8205, 16'h8403, 16'h1650, 16'hD600, 16'hF000, 16'h0, 16'h0, 16'h0), 16'h0008, 8'd10};
    vt[1] = '{mk(16'h827F, 16'h8440, 16'hA281, 16'h9881, 16'hD800, 16'hF000, 16'h0, 16'h0), 16'h007F, 8'd12};
    vt[2] = '{mk(16'h8241, 16'h9A40, 16'hDA00, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0), 16'h007F, 8'd8};
    vt[3] = '{mk(16'h83FF, 16'hD200, 16'hE241, 16'hD200, 16'hF000, 16'h0, 16'h0, 16'h0), 16'h0000, 8'd10};
    vt[4] = '{mk(16'h8201, 16'h840F, 16'h6650, 16'h8801, 16'h46E0, 16'h6AE0, 16'hDA00, 16'hF000),
              SHIFT_EN ? 16'h0002 : 16'h0000, 8'd16};
    vt[5] = '{mk(16'h8200, 16'h8403, 16'hE241, 16'hD200, 16'hB281, 16'hB03C, 16'hF000, 16'h0), 16'h0003, 8'd28};
    vt[6] = '{mk(16'hC004, 16'h8201, 16'hD200, 16'hF000, 16'h8255, 16'hD200, 16'hF000, 16'h0), 16'h0055, 8'd8};
    vt[7] = '{mk(16'h83FE, 16'h8403, 16'h2650, 16'h78D0, 16'hD800, 16'hF000, 16'h0, 16'h0),
              SHIFT_EN ? 16'h1FFF : 16'h0000, 8'd12};

    do_reset();
    check16("reset_out", out_data, 16'h0000);
    check16("reset_done", {15'b0, done}, 16'h0000);

    // Directed program table (vector 2 reads back RAM[0x41] stored by vector 1)
    for (int i = 0; i < 8; i++) begin
      do_reset();
      load_vec(i);
      run_until_done(200, e_n);
      check_int($sformatf("vec%0d_done_edge", i), e_n, int'(vt[i].exp_edge));
      check16($sformatf("vec%0d_out", i), out_data, vt[i].exp_out);
    end

    // Exact edge timing of the first test-plan program, plus hold after HALT
    do_reset();
    load_vec(0);
    E = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check16($sformatf("t1_out_e%0d", i), out_data, (i >= 8) ? 16'h0008 : 16'h0000);
      check16($sformatf("t1_done_e%0d", i), {15'b0, done}, (i >= 10) ? 16'h0001 : 16'h0000);
    end

    // 5-cycle stall after edge 4, and a load-port pulse while running must be ignored
    do_reset();
    E = 1'b1;
    Ram_addr = 16'h0003;
    Ram_data = 16'hF000;
    WR_RAM_E = 1'b1;
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      WR_RAM_E = 1'b0;
      if (E) c++;
      check16($sformatf("stall_out_e%0d", i), out_data, (c >= 8) ? 16'h0008 : 16'h0000);
      check16($sformatf("stall_done_e%0d", i), {15'b0, done}, (c >= 10) ? 16'h0001 : 16'h0000);
      E = (i >= 4 && i < 9) ? 1'b0 : 1'b1;
    end
    E = 1'b0;

    // Reset mid-run on the loop program, then rerun from preserved RAM
    do_reset();
    load_vec(5);
    E = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check16("mid_out_before_rst", out_data, 16'h0001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check16("mid_rst_out", out_data, 16'h0000);
    check16("mid_rst_done", {15'b0, done}, 16'h0000);
    for (int i = 1; i <= 30; i++) begin
      tick();
      check16($sformatf("loop_out_e%0d", i), out_data,
              (i >= 24) ? 16'h0003 : (i >= 16) ? 16'h0002 : (i >= 8) ? 16'h0001 : 16'h0000);
      check16($sformatf("loop_done_e%0d", i), {15'b0, done}, (i >= 28) ? 16'h0001 : 16'h0000);
    end

    // Halted core: load port usable with E=0, outputs keep holding
    E = 1'b0;
    tb_load(8'h10, 16'h1234);
    E = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check16("halt_hold_out", out_data, 16'h0003);
    check16("halt_hold_done", {15'b0, done}, 16'h0001);
    E = 1'b0;

    // Random programs against the ISA model, with occasional stall cycles
    for (int t = 0; t < 12; t++) begin
      do_reset();
      for (int a = 0; a < 256; a++) begin
        opr = 4'($urandom_range(0, 15));
        if (opr == 4'hF && $urandom_range(0, 3) != 0) opr = 4'hD;
        w = {opr, 12'($urandom)};
        tb_load(8'(a), w);
      end
      model_reset();
      for (int k = 0; k < 40; k++) begin
        if (!m_done) model_step();
        E = 1'b1;
        tick();
        tick();
        check16($sformatf("rnd%0d_i%0d_out", t, k), out_data, m_out);
        check16($sformatf("rnd%0d_i%0d_done", t, k), {15'b0, done}, {15'b0, m_done});
        if ($urandom_range(0, 7) == 0) begin
          E = 1'b0;
          tick();
          check16($sformatf("rnd%0d_i%0d_stall_out", t, k), out_data, m_out);
        end
      end
      E = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
